wb_regfile: RTL and testbench



---
 rtl/mips_pkg.sv | 10 +
 rtl/wb_regfile_wb_mux.sv | 15 +
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: register-file geometry, datapath width
// and the hardwired-zero register number.
package mips_pkg;

   localparam int unsigned NREGS    = 32;
   localparam int unsigned DW       = 32;
   localparam int unsigned AW       = $clog2(NREGS);
   localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Writeback value select: the load data or the ALU result, chosen by memtoreg.
module wb_mux #(
   parameter int unsigned DW = 32
) (
   input  logic          memtoreg,
   input  logic [DW-1:0] readdata,
   input  logic [DW-1:0] aluresult,
   output logic [DW-1:0] wbdata
);

   always_comb begin
      wbdata = memtoreg ? readdata : aluresult;
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: commits the MEM/WB bundle to the register file and counts commits.
// Optional macro WB_BYPASS_EN makes the read ports write-first within a cycle.
import mips_pkg::*;

module wb_regfile #(
   parameter int unsigned NREGS = mips_pkg::NREGS,
   parameter int unsigned DW    = mips_pkg::DW,
   parameter int unsigned CNTW  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     memtoreg,
   input  logic                     regwrite,
   input  logic [$clog2(NREGS)-1:0] writereg,
   input  logic [DW-1:0]            readdata,
   input  logic [DW-1:0]            aluresult,
   input  logic [$clog2(NREGS)-1:0] rs,
   input  logic [$clog2(NREGS)-1:0] rt,
   output logic [DW-1:0]            rsdata,
   output logic [DW-1:0]            rtdata,
   output logic [DW-1:0]            wbdata,
   output logic                     wbvalid,
   output logic [CNTW-1:0]          wbcount
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [DW-1:0]   regs_q [NREGS];
   logic [DW-1:0]   regs_d [NREGS];
   logic [CNTW-1:0] wbcount_q;
   logic [CNTW-1:0] wbcount_d;

   wb_mux #(
      .DW (DW)
   ) u_wb_mux (
      .memtoreg  (memtoreg),
      .readdata  (readdata),
      .aluresult (aluresult),
      .wbdata    (wbdata)
   );

   always_comb begin
      wbvalid = regwrite && (writereg != AW'(REG_ZERO));
   end

   always_comb begin
      regs_d    = regs_q;
      wbcount_d = wbcount_q;
      if (wbvalid) begin
         regs_d[writereg] = wbdata;
         wbcount_d        = wbcount_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         wbcount_q <= '0;
      end else begin
         regs_q    <= regs_d;
         wbcount_q <= wbcount_d;
      end
   end

   // Register 0 reads as zero regardless of storage; bypass never targets it.
   always_comb begin
      rsdata = regs_q[rs];
      rtdata = regs_q[rt];
`ifdef WB_BYPASS_EN
      if (wbvalid && (writereg == rs)) rsdata = wbdata;
      if (wbvalid && (writereg == rt)) rtdata = wbdata;
`endif
      if (rs == AW'(REG_ZERO)) rsdata = '0;
      if (rt == AW'(REG_ZERO)) rtdata = '0;
   end

   assign wbcount = wbcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile (4-bit commit counter to exercise wrap).
module tb_wb_regfile;

   localparam int unsigned CNTW = 4;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] v;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        memtoreg;
   logic        regwrite;
   logic [4:0]  writereg;
   logic [31:0] readdata;
   logic [31:0] aluresult;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [31:0] rsdata;
   logic [31:0] rtdata;
   logic [31:0] wbdata;
   logic        wbvalid;
   logic [CNTW-1:0] wbcount;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp_regs [32];
   int unsigned exp_cnt;
   wb_t         sb [$];

   wb_regfile #(
      .NREGS (32),
      .DW    (32),
      .CNTW  (CNTW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .memtoreg  (memtoreg),
      .regwrite  (regwrite),
      .writereg  (writereg),
      .readdata  (readdata),
      .aluresult (aluresult),
      .rs        (rs),
      .rt        (rt),
      .rsdata    (rsdata),
      .rtdata    (rtdata),
      .wbdata    (wbdata),
      .wbvalid   (wbvalid),
      .wbcount   (wbcount)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] cnt_exp();
      return 4'(exp_cnt % 16);
   endfunction

   function automatic logic [31:0] sel_exp(input logic m2r, input logic [31:0] rd,
                                           input logic [31:0] alu);
      return m2r ? rd : alu;
   endfunction

   // Expected read-port value given the bundle currently presented.
   function automatic logic [31:0] read_exp(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (!rst && regwrite && writereg != 5'd0 && writereg == a)
         return sel_exp(memtoreg, readdata, aluresult);
`endif
      return exp_regs[a];
   endfunction

   task automatic present(input logic rw, input logic m2r, input logic [4:0] wr,
                          input logic [31:0] rd, input logic [31:0] alu);
      regwrite  = rw;
      memtoreg  = m2r;
      writereg  = wr;
      readdata  = rd;
      aluresult = alu;
      if (!rst && rw && wr != 5'd0) sb.push_back('{r: wr, v: sel_exp(m2r, rd, alu)});
   endtask

   task automatic clock_edge();
      @(posedge clk);
      if (rst) begin
         foreach (exp_regs[i]) exp_regs[i] = 32'h0;
         exp_cnt = 0;
         sb.delete();
      end else if (regwrite && writereg != 5'd0) begin
         exp_regs[writereg] = sel_exp(memtoreg, readdata, aluresult);
         exp_cnt++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rs  = 5'd0;
      rt  = 5'd0;
      present(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF);
      clock_edge();
      clock_edge();
      rst = 1'b0;
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i);
         rt = 5'(31 - i);
         #1;
         tests_run++;
         if (rsdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rs[%0d]: got %h expected 0", i, rsdata);
         end
         tests_run++;
         if (rtdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rt[%0d]: got %h expected 0", 31 - i, rtdata);
         end
      end
      tests_run++;
      if (wbcount !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_count: got %0d expected 0", wbcount);
      end
   endtask

   task automatic test_alu_wb();
      wb_t e;
      present(1'b1, 1'b0, 5'd8, 32'hAAAA_5555, 32'h0000_1234);
      #1;
      tests_run++;
      if (wbdata !== 32'h0000_1234 || wbvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL alu_wbdata: got %h/%b expected 00001234/1", wbdata, wbvalid);
      end
      clock_edge();
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      e  = sb.pop_front();
      rs = e.r;
      #1;
      tests_run++;
      if (rsdata !== 32'h0000_1234 || wbcount !== 4'd1) begin
         tests_failed++;
         $display("FAIL alu_commit: got %h cnt %0d expected 00001234 cnt 1", rsdata, wbcount);
      end
   endtask

   task automatic test_load_wb();
      wb_t e;
      present(1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h0000_0001);
      #1;
      tests_run++;
      if (wbdata !== 32'hCAFE_F00D) begin
         tests_failed++;
         $display("FAIL load_wbdata: got %h expected cafef00d", wbdata);
      end
      clock_edge();
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      e  = sb.pop_front();
      rt = e.r;
      #1;
      tests_run++;
      if (rtdata !== 32'hCAFE_F00D || wbcount !== 4'd2) begin
         tests_failed++;
         $display("FAIL load_commit: got %h cnt %0d expected cafef00d cnt 2", rtdata, wbcount);
      end
   endtask

   task automatic test_zero_reg();
      present(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
      rs = 5'd0;
      #1;
      tests_run++;
      if (wbvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_wbvalid: got %b expected 0", wbvalid);
      end
      clock_edge();
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      tests_run++;
      if (rsdata !== 32'h0 || wbcount !== 4'd2) begin
         tests_failed++;
         $display("FAIL zero_commit: got %h cnt %0d expected 0 cnt 2", rsdata, wbcount);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] exp_now;
`ifdef WB_BYPASS_EN
      exp_now = 32'h22;
`else
      exp_now = 32'h11;
`endif
      present(1'b1, 1'b0, 5'd9, 32'h0, 32'h11);
      clock_edge();
      void'(sb.pop_front());
      rs = 5'd9;
      rt = 5'd9;
      present(1'b1, 1'b0, 5'd9, 32'h0, 32'h22);
      #1;
      tests_run++;
      if (rsdata !== exp_now || rtdata !== exp_now) begin
         tests_failed++;
         $display("FAIL same_cycle: got %h/%h expected %h", rsdata, rtdata, exp_now);
      end
      clock_edge();
      void'(sb.pop_front());
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      tests_run++;
      if (rsdata !== 32'h22 || rtdata !== 32'h22) begin
         tests_failed++;
         $display("FAIL same_cycle_next: got %h/%h expected 00000022", rsdata, rtdata);
      end
   endtask

   task automatic test_back_to_back();
      wb_t         e;
      logic        have;
      logic [31:0] rd, alu, exp_rs;
      for (int i = 0; i < 60; i++) begin
         have = (sb.size() != 0);
         if (have) begin
            e  = sb.pop_front();
            rs = e.r;
         end
         rt  = 5'($urandom_range(0, 31));
         rd  = $urandom;
         alu = $urandom;
         present(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 31)), rd, alu);
         #1;
         tests_run++;
         if (wbdata !== sel_exp(memtoreg, rd, alu)) begin
            tests_failed++;
            $display("FAIL b2b_wbdata[%0d]: got %h expected %h", i, wbdata, sel_exp(memtoreg, rd, alu));
         end
         if (have) begin
            exp_rs = read_exp(e.r);
            if (exp_rs != e.v && !(regwrite && writereg == e.r)) exp_rs = e.v;
            tests_run++;
            if (rsdata !== exp_rs) begin
               tests_failed++;
               $display("FAIL b2b_rs[%0d] r%0d: got %h expected %h", i, e.r, rsdata, exp_rs);
            end
         end
         tests_run++;
         if (rtdata !== read_exp(rt)) begin
            tests_failed++;
            $display("FAIL b2b_rt[%0d] r%0d: got %h expected %h", i, rt, rtdata, read_exp(rt));
         end
         clock_edge();
      end
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      while (sb.size() != 0) begin
         e  = sb.pop_front();
         rs = e.r;
         #1;
         tests_run++;
         if (rsdata !== e.v) begin
            tests_failed++;
            $display("FAIL b2b_drain r%0d: got %h expected %h", e.r, rsdata, e.v);
         end
      end
      tests_run++;
      if (wbcount !== cnt_exp()) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d expected %0d", wbcount, cnt_exp());
      end
   endtask

   task automatic test_wrap_and_reset();
      rst = 1'b1;
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      clock_edge();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         present(1'b1, 1'b0, 5'(1 + (i % 30)), 32'h0, 32'(i + 100));
         clock_edge();
      end
      sb.delete();
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      tests_run++;
      if (wbcount !== 4'd1) begin
         tests_failed++;
         $display("FAIL wrap_count: got %0d expected 1", wbcount);
      end
      rst = 1'b1;
      present(1'b1, 1'b0, 5'd3, 32'h0, 32'h3333_3333);
      clock_edge();
      rst = 1'b0;
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      rs = 5'd3;
      #1;
      tests_run++;
      if (rsdata !== 32'h0 || wbcount !== 4'd0) begin
         tests_failed++;
         $display("FAIL midreset: got %h cnt %0d expected 0 cnt 0", rsdata, wbcount);
      end
      present(1'b1, 1'b1, 5'd3, 32'h4444_4444, 32'h0);
      clock_edge();
      void'(sb.pop_front());
      present(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      tests_run++;
      if (rsdata !== 32'h4444_4444 || wbcount !== 4'd1) begin
         tests_failed++;
         $display("FAIL post_reset_commit: got %h cnt %0d expected 44444444 cnt 1", rsdata, wbcount);
      end
   endtask

   initial begin
      foreach (exp_regs[i]) exp_regs[i] = 32'h0;
      exp_cnt = 0;
      test_reset();
      test_alu_wb();
      test_load_wb();
      test_zero_reg();
      test_same_cycle();
      test_back_to_back();
      test_wrap_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
